align_framer: RTL and testbench

ALIGN_FRAMER -- requirements
Module: align_framer

---
 rtl/align_framer.sv | 115 +++++++++++
 tb/tb_align_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/align_framer.sv
// align_framer: hunts for a SYNC word, then writes FRAME_LEN consecutive
// valid words (sync included) to addresses 0..FRAME_LEN-1. Input words pass
// through one register stage before the state machine sees them.
// Optional build macro: ALIGN_FRAMER_TRAILER_CHECK_EN enables a check of the
// last word of each frame against TRAILER and drives the sticky err flag.
module align_framer #(
  parameter int              DW         = 16,
  parameter int              AW         = 5,
  parameter int              FRAME_LEN  = 18,
  parameter logic [DW-1:0]   SYNC       = 16'hAAAA,
  parameter int              CONTINUOUS = 0,
  parameter logic [DW-1:0]   TRAILER    = 16'h5555
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic          wena,
  output logic [AW-1:0] waddr,
  output logic          tag,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          err
);

  typedef enum logic [1:0] {HUNT, WRITE, DONE} state_t;

  // Address of the final write of a frame.
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  state_t        state_reg;
  logic [DW-1:0] in_reg;
  logic          in_valid_reg;
  logic [AW-1:0] addr_next;
  logic          is_last;

  assign addr_next = waddr + AW'(1);
  assign is_last   = (addr_next == LAST_ADDR);

  // Input stage: clearing it on reset keeps a word sampled just before
  // reset from being written once reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_reg       <= '0;
      in_valid_reg <= 1'b0;
    end else begin
      in_reg       <= in;
      in_valid_reg <= in_valid;
    end
  end

  // Framing state machine with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= HUNT;
      out        <= '0;
      wena       <= 1'b0;
      waddr      <= '1;
      tag        <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wena       <= 1'b0;
      frame_done <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (in_valid_reg && (in_reg == SYNC)) begin
            out       <= in_reg;
            wena      <= 1'b1;
            waddr     <= '0;
            tag       <= 1'b1;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          // Any value, SYNC included, is payload once a frame is open.
          if (in_valid_reg) begin
            out   <= in_reg;
            wena  <= 1'b1;
            waddr <= addr_next;
            if (is_last) begin
              frame_done <= 1'b1;
              if (frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
              state_reg <= (CONTINUOUS != 0) ? HUNT : DONE;
            end
          end
        end
        DONE: begin
          // Single-shot capture complete; idle until reset.
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

`ifdef ALIGN_FRAMER_TRAILER_CHECK_EN
  // Sticky trailer mismatch, raised together with frame_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((state_reg == WRITE) && in_valid_reg && is_last &&
                 (in_reg != TRAILER)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
  // TRAILER only matters when the trailer check is built in.
  logic unused_trailer;
  assign unused_trailer = ^TRAILER;
`endif

endmodule

// File: tb/tb_align_framer.sv
// Directed bench for align_framer: a vector table for the basic single-shot
// frame, then hand-written sequences for gaps, mid-frame SYNC, reset abort,
// back-to-back continuous frames and the trailer check.
module tb_align_framer;

`ifdef ALIGN_FRAMER_TRAILER_CHECK_EN
  localparam logic TRL = 1'b1;
`else
  localparam logic TRL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] din;

  logic [15:0] out0, out1;
  logic        wena0, wena1;
  logic [4:0]  waddr0, waddr1;
  logic        tag0, tag1;
  logic        fd0, fd1;
  logic [15:0] cnt0, cnt1;
  logic        err0, err1;

  align_framer #(.CONTINUOUS(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din),
    .out(out0), .wena(wena0), .waddr(waddr0), .tag(tag0),
    .frame_done(fd0), .frame_cnt(cnt0), .err(err0)
  );

  align_framer #(.CONTINUOUS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din),
    .out(out1), .wena(wena1), .waddr(waddr1), .tag(tag1),
    .frame_done(fd1), .frame_cnt(cnt1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] din;
    logic        e_wena;
    logic [4:0]  e_waddr;
    logic [15:0] e_out;
    logic        e_tag;
    logic        e_fd;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [15:0] out;
    logic        fd;
  } obs_t;

  vec_t vecs [25];
  obs_t log0 [$];
  obs_t log1 [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic tick(input logic r, input logic v, input logic [15:0] d);
    obs_t o0, o1;
    rst = r; in_valid = v; din = d;
    @(posedge clk);
    #1;
    o0.wena = wena0; o0.waddr = waddr0; o0.out = out0; o0.fd = fd0;
    o1.wena = wena1; o1.waddr = waddr1; o1.out = out1; o1.fd = fd1;
    log0.push_back(o0);
    log1.push_back(o1);
  endtask

  // SYNC, 1..16, then the given last word: 18 valid words.
  task automatic feed_frame(input logic [15:0] last);
    tick(1'b1, 1'b1, 16'hAAAA);
    for (int k = 1; k <= 16; k++) tick(1'b1, 1'b1, 16'(k));
    tick(1'b1, 1'b1, last);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din = '0;

    // ---- Vector table: single-shot frame on dut0 ----
    for (int r = 0; r < 25; r++) begin
      vecs[r].rst     = (r != 0);
      vecs[r].vld     = (r != 0);
      vecs[r].din     = (r == 1) ? 16'h1234 :
                        (r == 2) ? 16'hAAAA :
                        (r <= 19) ? 16'(r - 2) : 16'hAAAA;
      vecs[r].e_wena  = 1'b0;
      vecs[r].e_waddr = 5'h1F;
      vecs[r].e_out   = 16'h0000;
      vecs[r].e_tag   = 1'b0;
      vecs[r].e_fd    = 1'b0;
      vecs[r].e_cnt   = 16'd0;
      vecs[r].e_err   = 1'b0;
      if (r >= 3 && r <= 20) begin
        vecs[r].e_wena  = 1'b1;
        vecs[r].e_waddr = 5'(r - 3);
        vecs[r].e_out   = (r == 3) ? 16'hAAAA : 16'(r - 3);
        vecs[r].e_tag   = 1'b1;
        vecs[r].e_fd    = (r == 20);
        vecs[r].e_cnt   = (r == 20) ? 16'd1 : 16'd0;
        vecs[r].e_err   = (r == 20) ? TRL : 1'b0;
      end else if (r > 20) begin
        vecs[r].e_waddr = 5'd17;
        vecs[r].e_out   = 16'd17;
        vecs[r].e_tag   = 1'b1;
        vecs[r].e_cnt   = 16'd1;
        vecs[r].e_err   = TRL;
      end
    end

    for (int r = 0; r < 25; r++) begin
      tick(vecs[r].rst, vecs[r].vld, vecs[r].din);
      chk("tbl_wena",  r, 32'(wena0),  32'(vecs[r].e_wena));
      chk("tbl_waddr", r, 32'(waddr0), 32'(vecs[r].e_waddr));
      chk("tbl_out",   r, 32'(out0),   32'(vecs[r].e_out));
      chk("tbl_tag",   r, 32'(tag0),   32'(vecs[r].e_tag));
      chk("tbl_fd",    r, 32'(fd0),    32'(vecs[r].e_fd));
      chk("tbl_cnt",   r, 32'(cnt0),   32'(vecs[r].e_cnt));
      chk("tbl_err",   r, 32'(err0),   32'(vecs[r].e_err));
    end

    // ---- Gap of 3 after word 5, SYNC value as word 9 (dut0) ----
    tick(1'b0, 1'b0, 16'h0);
    log0.delete(); log1.delete();
    tick(1'b1, 1'b1, 16'hAAAA);
    for (int k = 1; k <= 5; k++) tick(1'b1, 1'b1, 16'(k));
    for (int g = 0; g < 3; g++) tick(1'b1, 1'b0, 16'hBEEF);
    for (int k = 6; k <= 17; k++) tick(1'b1, 1'b1, (k == 9) ? 16'hAAAA : 16'(k));
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 23; i++) begin
      logic        ew;
      logic [4:0]  ea;
      logic [15:0] eo;
      logic        ef;
      ew = 1'b0; ea = 5'h1F; eo = 16'h0; ef = 1'b0;
      if (i >= 1 && i <= 6) begin
        ew = 1'b1; ea = 5'(i - 1); eo = (i == 1) ? 16'hAAAA : 16'(i - 1);
      end else if (i >= 7 && i <= 9) begin
        ea = 5'd5; eo = 16'd5;
      end else if (i >= 10 && i <= 21) begin
        ew = 1'b1; ea = 5'(i - 4); eo = (i == 13) ? 16'hAAAA : 16'(i - 4);
        ef = (i == 21);
      end else if (i == 22) begin
        ea = 5'd17; eo = 16'd17;
      end
      chk("gap_wena",  i, 32'(log0[i].wena),  32'(ew));
      chk("gap_waddr", i, 32'(log0[i].waddr), 32'(ea));
      chk("gap_out",   i, 32'(log0[i].out),   32'(eo));
      chk("gap_fd",    i, 32'(log0[i].fd),    32'(ef));
    end
    chk("gap_cnt", 0, 32'(cnt0), 32'd1);

    // ---- Reset at waddr 10 with a SYNC value already staged (dut0) ----
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'hAAAA);
    for (int k = 1; k <= 10; k++) tick(1'b1, 1'b1, 16'(k));
    tick(1'b1, 1'b1, 16'hAAAA);
    chk("rst_pre_waddr", 0, 32'(waddr0), 32'd10);
    tick(1'b0, 1'b1, 16'hAAAA);
    chk("rst_wena",  0, 32'(wena0),  32'd0);
    chk("rst_waddr", 0, 32'(waddr0), 32'h1F);
    chk("rst_out",   0, 32'(out0),   32'h0);
    chk("rst_tag",   0, 32'(tag0),   32'd0);
    chk("rst_fd",    0, 32'(fd0),    32'd0);
    chk("rst_cnt",   0, 32'(cnt0),   32'd0);
    chk("rst_err",   0, 32'(err0),   32'd0);
    tick(1'b1, 1'b0, 16'h0);
    chk("rst_stale_wena", 0, 32'(wena0), 32'd0);
    tick(1'b1, 1'b1, 16'h0007);
    chk("rst_hunt_wena", 0, 32'(wena0), 32'd0);
    tick(1'b1, 1'b1, 16'hAAAA);
    chk("rst_hunt_wena", 1, 32'(wena0), 32'd0);
    tick(1'b1, 1'b1, 16'h0001);
    chk("rst_restart_wena",  0, 32'(wena0),  32'd1);
    chk("rst_restart_waddr", 0, 32'(waddr0), 32'd0);
    chk("rst_restart_out",   0, 32'(out0),   32'hAAAA);
    chk("rst_restart_tag",   0, 32'(tag0),   32'd1);

    // ---- Two back-to-back frames: dut1 continuous, dut0 single-shot ----
    tick(1'b0, 1'b0, 16'h0);
    log0.delete(); log1.delete();
    for (int n = 0; n < 36; n++)
      tick(1'b1, 1'b1, ((n % 18) == 0) ? 16'hAAAA : 16'(n % 18));
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    chk("b2b_first_wena", 0, 32'(log1[0].wena), 32'd0);
    for (int n = 0; n < 36; n++) begin
      chk("b2b_wena",  n, 32'(log1[n+1].wena),  32'd1);
      chk("b2b_waddr", n, 32'(log1[n+1].waddr), 32'(n % 18));
      chk("b2b_out",   n, 32'(log1[n+1].out),
          ((n % 18) == 0) ? 32'hAAAA : 32'(n % 18));
      chk("b2b_fd",    n, 32'(log1[n+1].fd),    32'((n % 18) == 17));
    end
    chk("b2b_tail_wena", 0, 32'(log1[37].wena), 32'd0);
    chk("b2b_cnt", 0, 32'(cnt1), 32'd2);
    begin
      int extra;
      extra = 0;
      for (int i = 19; i < 38; i++) extra += int'(log0[i].wena);
      chk("single_done_writes", 0, 32'(extra), 32'd0);
    end
    chk("single_cnt", 0, 32'(cnt0), 32'd1);

    // ---- Trailer check on dut1 ----
    tick(1'b0, 1'b0, 16'h0);
    chk("trl_rst_err", 0, 32'(err1), 32'd0);
    feed_frame(16'h5555);
    tick(1'b1, 1'b0, 16'h0);
    chk("trl_ok_fd",  0, 32'(fd1),  32'd1);
    chk("trl_ok_err", 0, 32'(err1), 32'd0);
    feed_frame(16'h5556);
    tick(1'b1, 1'b0, 16'h0);
    chk("trl_bad_fd",  0, 32'(fd1),  32'd1);
    chk("trl_bad_err", 0, 32'(err1), 32'(TRL));
    tick(1'b1, 1'b0, 16'h0);
    chk("trl_hold_err", 0, 32'(err1), 32'(TRL));
    feed_frame(16'h5555);
    tick(1'b1, 1'b0, 16'h0);
    chk("trl_sticky_err", 0, 32'(err1), 32'(TRL));
    chk("trl_cnt", 0, 32'(cnt1), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
